// File: rtl/instr_decode_if.sv
// rtl/instr_decode_if.sv - decode-stage bus: fetch input/redirect, writeback, EX/MEM hazard info, ID/EX register
interface instr_decode_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int REG_AW      = 5
);
  logic [INSTR_WIDTH-1:0] instr_in_87;
  logic [ADDR_WIDTH-1:0]  npc_in_87;
  logic                   wb_we_87;
  logic [REG_AW-1:0]      wb_addr_87;
  logic [DATA_WIDTH-1:0]  wb_data_87;
  logic [REG_AW-1:0]      mem_rd_87;
  logic                   mem_mem_read_87;
  logic [ADDR_WIDTH-1:0]  fetch_pc_87;
  logic                   fetch_sel_87;
  logic [DATA_WIDTH-1:0]  rs_data_87;
  logic [DATA_WIDTH-1:0]  rt_data_87;
  logic [DATA_WIDTH-1:0]  imm_87;
  logic [REG_AW-1:0]      rs_87;
  logic [REG_AW-1:0]      rt_87;
  logic [REG_AW-1:0]      dst_87;
  logic                   reg_write_87;
  logic                   mem_read_87;
  logic                   mem_write_87;
  logic                   mem_to_reg_87;
  logic                   alu_src_87;
  logic [3:0]             alu_op_87;
  logic                   illegal_87;

  modport master (
    output instr_in_87, npc_in_87, wb_we_87, wb_addr_87, wb_data_87, mem_rd_87, mem_mem_read_87,
    input  fetch_pc_87, fetch_sel_87, rs_data_87, rt_data_87, imm_87, rs_87, rt_87, dst_87,
           reg_write_87, mem_read_87, mem_write_87, mem_to_reg_87, alu_src_87, alu_op_87, illegal_87
  );

  modport slave (
    input  instr_in_87, npc_in_87, wb_we_87, wb_addr_87, wb_data_87, mem_rd_87, mem_mem_read_87,
    output fetch_pc_87, fetch_sel_87, rs_data_87, rt_data_87, imm_87, rs_87, rt_87, dst_87,
           reg_write_87, mem_read_87, mem_write_87, mem_to_reg_87, alu_src_87, alu_op_87, illegal_87
  );
endinterface

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - MIPS decode stage: register file, control decode, in-stage beq/j, replay on hazards
module instr_decode #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int REG_AW      = 5
) (
  input logic           clk_87,
  input logic           rst_87,
  instr_decode_if.slave bus
);
  localparam int NREGS = 1 << REG_AW;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_SLT = 4'd4;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];

  logic [INSTR_WIDTH-1:0] instr;
  logic [5:0]             op, funct;
  logic [REG_AW-1:0]      rs, rt, rd;
  assign instr = bus.instr_in_87;
  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];

  always_ff @(posedge clk_87) begin
    if (rst_87) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (bus.wb_we_87 && bus.wb_addr_87 != '0) begin
      regs_q[bus.wb_addr_87] <= bus.wb_data_87;
    end
  end

  // Write-first read ports: a same-cycle writeback is visible to decode.
  logic [DATA_WIDTH-1:0] rs_val, rt_val;
  always_comb begin
    rs_val = regs_q[rs];
    if (rs == '0) rs_val = '0;
    else if (bus.wb_we_87 && bus.wb_addr_87 == rs) rs_val = bus.wb_data_87;
    rt_val = regs_q[rt];
    if (rt == '0) rt_val = '0;
    else if (bus.wb_we_87 && bus.wb_addr_87 == rt) rt_val = bus.wb_data_87;
  end

  logic            dec_rw, dec_mr, dec_mw, dec_m2r, dec_as, dec_ill;
  logic            is_beq, is_j, uses_rt;
  logic [3:0]      dec_op;
  logic [REG_AW-1:0] dec_dst;
  always_comb begin
    dec_rw = 1'b0; dec_mr = 1'b0; dec_mw = 1'b0; dec_m2r = 1'b0; dec_as = 1'b0;
    dec_ill = 1'b0; is_beq = 1'b0; is_j = 1'b0; uses_rt = 1'b0;
    dec_op = ALU_ADD; dec_dst = '0;
    case (op)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        dec_dst = rd;
        case (funct)
          6'h20: dec_rw = 1'b1;
          6'h22: begin dec_rw = 1'b1; dec_op = ALU_SUB; end
          6'h24: begin dec_rw = 1'b1; dec_op = ALU_AND; end
          6'h25: begin dec_rw = 1'b1; dec_op = ALU_OR;  end
          6'h2A: begin dec_rw = 1'b1; dec_op = ALU_SLT; end
          6'h00: ;
          default: dec_ill = 1'b1;
        endcase
      end
      OP_LW:   begin dec_dst = rt; dec_rw = 1'b1; dec_mr = 1'b1; dec_m2r = 1'b1; dec_as = 1'b1; end
      OP_SW:   begin uses_rt = 1'b1; dec_mw = 1'b1; dec_as = 1'b1; end
      OP_ADDI: begin dec_dst = rt; dec_rw = 1'b1; dec_as = 1'b1; end
      OP_BEQ:  begin uses_rt = 1'b1; is_beq = 1'b1; end
      OP_J:    is_j = 1'b1;
      default: dec_ill = 1'b1;
    endcase
  end

  logic              reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, alu_src_q, illegal_q;
  logic [3:0]        alu_op_q;
  logic [REG_AW-1:0] rs_q, rt_q, dst_q;
  logic [DATA_WIDTH-1:0] rs_data_q, rt_data_q, imm_q;

  logic load_use, beq_haz, stall;
  always_comb begin
    load_use = mem_read_q && dst_q != '0 && (dst_q == rs || (uses_rt && dst_q == rt));
    beq_haz  = is_beq &&
               ((rs != '0 && ((reg_write_q && rs == dst_q) || (bus.mem_mem_read_87 && rs == bus.mem_rd_87))) ||
                (rt != '0 && ((reg_write_q && rt == dst_q) || (bus.mem_mem_read_87 && rt == bus.mem_rd_87))));
    stall    = load_use || beq_haz;
  end

  // Fetch uses the selected PC in the same cycle, so there is no delay slot.
  logic [ADDR_WIDTH-1:0] br_off;
  assign br_off = {{(ADDR_WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
  always_comb begin
    bus.fetch_pc_87  = bus.npc_in_87;
    bus.fetch_sel_87 = 1'b0;
    if (stall) begin
      bus.fetch_sel_87 = 1'b1;
      bus.fetch_pc_87  = bus.npc_in_87 - ADDR_WIDTH'(4);
    end else if (is_j) begin
      bus.fetch_sel_87 = 1'b1;
      bus.fetch_pc_87  = {bus.npc_in_87[ADDR_WIDTH-1:ADDR_WIDTH-4], instr[25:0], 2'b00};
    end else if (is_beq && rs_val == rt_val) begin
      bus.fetch_sel_87 = 1'b1;
      bus.fetch_pc_87  = bus.npc_in_87 + br_off;
    end
    if (rst_87) bus.fetch_sel_87 = 1'b0;
  end

  logic bubble;
  logic reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d, alu_src_d, illegal_d;
  logic [3:0] alu_op_d;
  always_comb begin
    bubble       = stall || dec_ill;
    reg_write_d  = !bubble && dec_rw && dec_dst != '0;
    mem_read_d   = !bubble && dec_mr;
    mem_write_d  = !bubble && dec_mw;
    mem_to_reg_d = !bubble && dec_m2r;
    alu_src_d    = !bubble && dec_as;
    alu_op_d     = bubble ? ALU_ADD : dec_op;
    illegal_d    = !stall && dec_ill;
  end

  always_ff @(posedge clk_87) begin
    if (rst_87) begin
      reg_write_q <= 1'b0; mem_read_q <= 1'b0; mem_write_q <= 1'b0; mem_to_reg_q <= 1'b0;
      alu_src_q <= 1'b0; illegal_q <= 1'b0; alu_op_q <= '0;
      rs_q <= '0; rt_q <= '0; dst_q <= '0;
      rs_data_q <= '0; rt_data_q <= '0; imm_q <= '0;
    end else begin
      reg_write_q <= reg_write_d; mem_read_q <= mem_read_d; mem_write_q <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d; alu_src_q <= alu_src_d; illegal_q <= illegal_d; alu_op_q <= alu_op_d;
      rs_q <= rs; rt_q <= rt; dst_q <= dec_dst;
      rs_data_q <= rs_val; rt_data_q <= rt_val;
      imm_q <= {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};
    end
  end

  assign bus.reg_write_87  = reg_write_q;
  assign bus.mem_read_87   = mem_read_q;
  assign bus.mem_write_87  = mem_write_q;
  assign bus.mem_to_reg_87 = mem_to_reg_q;
  assign bus.alu_src_87    = alu_src_q;
  assign bus.alu_op_87     = alu_op_q;
  assign bus.illegal_87    = illegal_q;
  assign bus.rs_87         = rs_q;
  assign bus.rt_87         = rt_q;
  assign bus.dst_87        = dst_q;
  assign bus.rs_data_87    = rs_data_q;
  assign bus.rt_data_87    = rt_data_q;
  assign bus.imm_87        = imm_q;
endmodule

// File: tb/tb_instr_decode.sv
// tb/tb_instr_decode.sv - scoreboard bench for instr_decode with a mnemonic-level reference model
module tb_instr_decode;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_decode_if bus ();
  instr_decode dut (.clk_87(clk), .rst_87(rst), .bus(bus));

  typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_NOP, M_LW, M_SW, M_ADDI, M_BEQ, M_J, M_ILL} mn_t;

  typedef struct {
    logic rw, mr, mw, m2r, as, ill;
    logic [3:0] op;
    logic [31:0] rsd, rtd, imm;
    logic [4:0] rs, rt, dst;
    bit chk_data, chk_dst;
  } rec_t;

  rec_t sbq[$];
  rec_t m_q;
  rec_t mon_e;
  logic [31:0] mregs [32];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t zero_rec();
    rec_t z;
    z.rw = 0; z.mr = 0; z.mw = 0; z.m2r = 0; z.as = 0; z.ill = 0; z.op = 0;
    z.rsd = 0; z.rtd = 0; z.imm = 0; z.rs = 0; z.rt = 0; z.dst = 0;
    z.chk_data = 0; z.chk_dst = 0;
    return z;
  endfunction

  function automatic mn_t classify(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: return M_ADD;
        6'h22: return M_SUB;
        6'h24: return M_AND;
        6'h25: return M_OR;
        6'h2A: return M_SLT;
        6'h00: return M_NOP;
        default: return M_ILL;
      endcase
      6'h23: return M_LW;
      6'h2B: return M_SW;
      6'h08: return M_ADDI;
      6'h04: return M_BEQ;
      6'h02: return M_J;
      default: return M_ILL;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (we && wa == idx) return wd;
    return mregs[idx];
  endfunction

  task automatic apply(input logic r, input logic [31:0] ins, input logic [31:0] npc,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] mrd, input logic mmr);
    rec_t e;
    mn_t m;
    logic [4:0] rs, rt, rd, dst;
    logic [31:0] rsv, rtv, exp_pc;
    bit is_r, writes, ur, lu, bh, st, exp_sel;
    @(negedge clk);
    rst = r;
    bus.instr_in_87 = ins; bus.npc_in_87 = npc;
    bus.wb_we_87 = we; bus.wb_addr_87 = wa; bus.wb_data_87 = wd;
    bus.mem_rd_87 = mrd; bus.mem_mem_read_87 = mmr;
    #1;
    e = zero_rec();
    if (r) begin
      e.chk_data = 1; e.chk_dst = 1;
      chk("fetch_sel_rst", bus.fetch_sel_87, 0);
    end else begin
      m = classify(ins);
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      is_r   = m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT};
      writes = is_r || m inside {M_LW, M_ADDI};
      dst    = is_r ? rd : (m inside {M_LW, M_ADDI}) ? rt : 5'd0;
      ur     = (ins[31:26] == 0) || m inside {M_SW, M_BEQ};
      rsv = model_read(rs, we, wa, wd);
      rtv = model_read(rt, we, wa, wd);
      lu = m_q.mr && m_q.dst != 0 && (m_q.dst == rs || (ur && m_q.dst == rt));
      bh = (m == M_BEQ) &&
           ((rs != 0 && ((m_q.rw && rs == m_q.dst) || (mmr && rs == mrd))) ||
            (rt != 0 && ((m_q.rw && rt == m_q.dst) || (mmr && rt == mrd))));
      st = lu || bh;
      exp_sel = 1; exp_pc = npc;
      if (st) exp_pc = npc - 4;
      else if (m == M_J) exp_pc = (npc & 32'hF000_0000) + (ins & 32'h03FF_FFFF) * 4;
      else if (m == M_BEQ && rsv == rtv) exp_pc = npc + 32'(int'($signed(ins[15:0])) * 4);
      else exp_sel = 0;
      chk("fetch_sel", bus.fetch_sel_87, exp_sel);
      chk("fetch_pc", bus.fetch_pc_87, exp_pc);
      if (!st && m == M_ILL) e.ill = 1;
      if (!st && m != M_ILL) begin
        e.rw  = writes && dst != 0;
        e.mr  = (m == M_LW);
        e.m2r = (m == M_LW);
        e.mw  = (m == M_SW);
        e.as  = m inside {M_LW, M_SW, M_ADDI};
        e.op  = (m == M_SUB) ? 4'd1 : (m == M_AND) ? 4'd2 : (m == M_OR) ? 4'd3 : (m == M_SLT) ? 4'd4 : 4'd0;
        e.dst = dst;
        e.rs = rs; e.rt = rt; e.rsd = rsv; e.rtd = rtv;
        e.imm = 32'(int'($signed(ins[15:0])));
        e.chk_data = 1;
        e.chk_dst  = e.rw;
      end
    end
    sbq.push_back(e);
    m_q = e;
    if (r) for (int i = 0; i < 32; i++) mregs[i] = 0;
    else if (we && wa != 0) mregs[wa] = wd;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("reg_write", bus.reg_write_87, mon_e.rw);
        chk("mem_read", bus.mem_read_87, mon_e.mr);
        chk("mem_write", bus.mem_write_87, mon_e.mw);
        chk("mem_to_reg", bus.mem_to_reg_87, mon_e.m2r);
        chk("alu_src", bus.alu_src_87, mon_e.as);
        chk("alu_op", bus.alu_op_87, mon_e.op);
        chk("illegal", bus.illegal_87, mon_e.ill);
        if (mon_e.chk_data) begin
          chk("rs_data", bus.rs_data_87, mon_e.rsd);
          chk("rt_data", bus.rt_data_87, mon_e.rtd);
          chk("imm", bus.imm_87, mon_e.imm);
          chk("rs", bus.rs_87, mon_e.rs);
          chk("rt", bus.rt_87, mon_e.rt);
        end
        if (mon_e.chk_dst) chk("dst", bus.dst_87, mon_e.dst);
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [5:0] fn [7];
    logic [31:0] w;
    fn[0] = 6'h20; fn[1] = 6'h22; fn[2] = 6'h24; fn[3] = 6'h25; fn[4] = 6'h2A; fn[5] = 6'h00; fn[6] = 6'h21;
    w = $urandom;
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0, 1, 2: begin w[31:26] = 6'h00; w[15:11] = 5'($urandom_range(0, 3)); w[5:0] = fn[$urandom_range(0, 6)]; end
      3: w[31:26] = 6'h23;
      4: w[31:26] = 6'h2B;
      5: w[31:26] = 6'h08;
      6, 7: w[31:26] = 6'h04;
      8: w[31:26] = 6'h02;
      default: w[31:26] = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'h0F;
    endcase
    return w;
  endfunction

  initial begin
    m_q = zero_rec();
    for (int i = 0; i < 32; i++) mregs[i] = 0;
    bus.instr_in_87 = 0; bus.npc_in_87 = 0; bus.wb_we_87 = 0; bus.wb_addr_87 = 0;
    bus.wb_data_87 = 0; bus.mem_rd_87 = 0; bus.mem_mem_read_87 = 0;

    apply(1, 32'h0, 32'h4, 0, 0, 0, 0, 0);
    apply(1, 32'h0, 32'h4, 0, 0, 0, 0, 0);
    apply(0, 32'h0, 32'h4, 0, 0, 0, 0, 0);
    for (int k = 1; k < 32; k++)
      apply(0, {6'h00, 5'(k), 5'(k), 5'd0, 5'd0, 6'h20}, 32'h8, 0, 0, 0, 0, 0);

    apply(0, 32'h0, 32'h4, 1, 5'd1, 32'd5, 0, 0);
    apply(0, 32'h0, 32'h4, 1, 5'd2, 32'd7, 0, 0);
    apply(0, 32'h0022_1820, 32'h4, 0, 0, 0, 0, 0);
    apply(0, 32'h0020_2025, 32'h8, 1, 5'd1, 32'hAA, 0, 0);
    chk("add_rs_data", bus.rs_data_87, 32'd5);
    chk("add_rt_data", bus.rt_data_87, 32'd7);
    chk("add_dst", bus.dst_87, 32'd3);
    chk("add_reg_write", bus.reg_write_87, 1);
    apply(0, 32'h8C22_0000, 32'h8, 0, 0, 0, 0, 0);
    chk("bypass_rs_data", bus.rs_data_87, 32'hAA);
    apply(0, 32'h0042_1820, 32'hC, 0, 0, 0, 0, 0);
    chk("lu_sel", bus.fetch_sel_87, 1);
    chk("lu_pc", bus.fetch_pc_87, 32'h8);
    apply(0, 32'h0042_1820, 32'hC, 0, 0, 0, 0, 0);
    chk("lu_bubble", bus.reg_write_87 | bus.mem_read_87, 0);
    chk("replay_sel", bus.fetch_sel_87, 0);
    apply(0, 32'h0, 32'h10, 0, 0, 0, 0, 0);
    chk("replay_rw", bus.reg_write_87, 1);
    apply(0, 32'h1000_0003, 32'h14, 0, 0, 0, 0, 0);
    chk("beq_sel", bus.fetch_sel_87, 1);
    chk("beq_pc", bus.fetch_pc_87, 32'h20);
    apply(0, 32'h0800_0010, 32'h24, 0, 0, 0, 0, 0);
    chk("j_pc", bus.fetch_pc_87, 32'h40);
    apply(0, 32'hFC00_0000, 32'h28, 0, 0, 0, 0, 0);
    chk("ill_sel", bus.fetch_sel_87, 0);
    apply(0, 32'h0, 32'h2C, 0, 0, 0, 0, 0);
    chk("ill_pulse", bus.illegal_87, 1);
    apply(0, 32'h0, 32'h30, 0, 0, 0, 0, 0);
    chk("ill_clear", bus.illegal_87, 0);
    apply(0, 32'h8C22_0000, 32'h8, 0, 0, 0, 0, 0);
    apply(1, 32'h0042_1820, 32'hC, 0, 0, 0, 0, 0);
    apply(0, 32'h0, 32'h4, 0, 0, 0, 0, 0);
    chk("rst_mid_stall", bus.mem_read_87, 0);

    for (int n = 0; n < 3000; n++)
      apply(($urandom_range(0, 63) == 0), rand_instr(), $urandom & 32'hFFFF_FFFC,
            1'($urandom), 5'($urandom_range(0, 3)), $urandom,
            5'($urandom_range(0, 3)), 1'($urandom));

    apply(0, 32'h0, 32'h4, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("sb_drain", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Decode stage of the 5-stage MIPS pipeline. It sits directly downstream of instruction fetch and consumes that stage's registered instr_87/npc_87.
- Holds the 32x32 register file, with the write port driven by writeback.
- Decodes control, sign-extends immediates, and resolves beq/j in-stage. Redirects fetch combinationally through the fetch stage's pc_87/sel_87 inputs.
- Detects load-use and branch-operand hazards and handles them by replay (re-fetching the current instruction) plus a bubble. Drives the ID/EX pipeline register.

Parameters:
DATA_WIDTH, 32, register/operand width
ADDR_WIDTH, 32, PC width (matches `ADDR_WIDTH)
INSTR_WIDTH, 32, instruction width (matches `INSTR_WIDTH)
REG_AW, 5, register index width

Ports:
clk_87  in  1  clock, rising edge
rst_87  in  1  synchronous active-high reset
instr_in_87  in  INSTR_WIDTH  instruction from fetch
npc_in_87  in  ADDR_WIDTH  address of instr_in_87 plus 4, from fetch
wb_we_87  in  1  writeback write enable
wb_addr_87  in  REG_AW  writeback register
wb_data_87  in  DATA_WIDTH  writeback data
mem_rd_87  in  REG_AW  EX/MEM destination register
mem_mem_read_87  in  1  EX/MEM instruction is lw
fetch_pc_87  out  ADDR_WIDTH  redirect PC to fetch (combinational)
fetch_sel_87  out  1  redirect enable to fetch (combinational)
rs_data_87  out  DATA_WIDTH  ID/EX rs operand
rt_data_87  out  DATA_WIDTH  ID/EX rt operand
imm_87  out  DATA_WIDTH  ID/EX sign-extended imm16
rs_87, rt_87, dst_87  out  REG_AW each  ID/EX source and destination indices
reg_write_87, mem_read_87, mem_write_87, mem_to_reg_87, alu_src_87  out  1 each  ID/EX control
alu_op_87  out  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
illegal_87  out  1  registered one-cycle pulse for an unsupported instruction

Behaviour:
- Reset (rst_87=1 at a clock edge):
  - All ID/EX outputs and illegal_87 go to 0.
  - All 32 registers are cleared.
  - fetch_sel_87=0 combinationally while rst_87 is high.
- Register file:
  - Synchronous write on wb_we_87 when wb_addr_87!=0; writes to $0 are ignored.
  - Reads are combinational with write-first bypass: if the read index equals wb_addr_87, wb_we_87=1 and the index is nonzero, read data is wb_data_87 in the same cycle.
  - $0 always reads 0.
- Decode (op=instr[31:26], funct=instr[5:0]):
  - op 0x00, funct 0x20/0x22/0x24/0x25/0x2A: ADD/SUB/AND/OR/SLT. dst=rd, reg_write=1, alu_src=0.
  - op 0x00 with funct 0x00: nop (sll). All control is 0; the all-zero word fetched during reset is therefore a nop.
  - op 0x23 lw: dst=rt, reg_write, mem_read, mem_to_reg, alu_src, ADD.
  - op 0x2B sw: mem_write, alu_src, ADD, reg_write=0.
  - op 0x08 addi: dst=rt, reg_write, alu_src, ADD.
  - op 0x04 beq: no ID/EX control. Target = npc_in + (sext(imm16)<<2), modulo 2^ADDR_WIDTH.
  - op 0x02 j: no ID/EX control. Target = {npc_in[31:28], instr[25:0], 2'b00}.
  - Any other op/funct: bubble into ID/EX; illegal_87=1 for one cycle.
  - reg_write is forced to 0 when dst=0.
- Hazards (combinational, on the current instruction):
  - load-use: the ID/EX register holds mem_read=1 with dst!=0, and dst equals a source this instruction uses. Sources are rs for all types; rt for R-type, sw and beq.
  - beq operand hazard: rs or rt (nonzero) equals the ID/EX dst with reg_write=1, or equals mem_rd_87 with mem_mem_read_87=1.
  - stall = load-use OR beq operand hazard.
- Redirect, in priority order:
  1. stall: fetch_sel=1, fetch_pc=npc_in-4 (replay), and a bubble is clocked into ID/EX.
  2. j: fetch_sel=1, fetch_pc=jump target.
  3. beq with rs_data==rt_data: fetch_sel=1, fetch_pc=branch target.
  4. Otherwise fetch_sel=0 and fetch_pc=npc_in.
  - Because fetch addresses memory with the selected PC in the same cycle, there is no delay slot and no flush.
- ID/EX latency: one cycle. A bubble clears every control bit and illegal_87; data fields are don't-care.
- Simultaneous WB write and read of the same register: the bypassed value is used for both the beq compare and the ID/EX operand.
- Reset asserted mid-stall: reset wins; ID/EX is cleared and fetch_sel_87=0.

Test Plan:
- Reset: hold rst_87 for 2 cycles, then feed instr 0x00000000 -> all ID/EX control 0, fetch_sel_87=0, $1..$31 read 0.
- add $3,$1,$2 (0x00221820) with $1=5, $2=7 (both via WB) -> next cycle rs_data=5, rt_data=7, dst=3, reg_write=1, alu_op=0.
- WB bypass: wb_we_87=1, wb_addr_87=1, wb_data_87=0xAA in the same cycle as decoding "or $4,$1,$0" -> rs_data_87=0xAA.
- Load-use: lw $2,0($1) at npc 0x8, then add $3,$2,$2 at npc 0xC -> fetch_sel=1, fetch_pc=0x8, bubble in ID/EX. Replayed add issues the next cycle with reg_write=1.
- beq $0,$0,+3 at npc 0x14 -> fetch_sel=1, fetch_pc=0x20. j 0x40 (0x08000010) at npc 0x24 -> fetch_pc=0x40.
- Illegal op 0x3F -> illegal_87=1 for exactly one cycle, all ID/EX control 0, fetch_sel=0.
